// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared ALU control codes and HI/LO unit types.
// Imported by the ALU control block and the HI/LO mult/div unit.
package hilo_muldiv_unit_pkg;

    localparam int HILO_WIDTH = 32;

    localparam logic [3:0] ALUCTL_AND  = 4'h0;
    localparam logic [3:0] ALUCTL_OR   = 4'h1;
    localparam logic [3:0] ALUCTL_ADD  = 4'h2;
    localparam logic [3:0] ALUCTL_MFHI = 4'h3;
    localparam logic [3:0] ALUCTL_MFLO = 4'h4;
    localparam logic [3:0] ALUCTL_MULT = 4'h5;
    localparam logic [3:0] ALUCTL_SUB  = 4'h6;
    localparam logic [3:0] ALUCTL_SLT  = 4'h7;
    localparam logic [3:0] ALUCTL_DIV  = 4'h8;
    localparam logic [3:0] ALUCTL_NOR  = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } hilo_state_t;

endpackage

// File: rtl/hilo_muldiv_unit_iter_core.sv
// Unsigned magnitude datapath: shift-add multiply or restoring divide.
// One bit per step; 'last' flags the final step of the run.
module hilo_iter_core
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] upper,
    output logic [WIDTH-1:0] lower,
    output logic             last
);

    logic [WIDTH-1:0] up_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opd_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] nxt_up;
    logic [WIDTH-1:0] nxt_lo;

    // One iteration: mult adds/shifts right, div shifts left/subtracts.
    always_comb begin
        sum     = {1'b0, up_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        shifted = {up_q, lo_q[WIDTH-1]};
        rem_sub = shifted[WIDTH-1:0] - opd_q;
        nxt_up  = sum[WIDTH:1];
        nxt_lo  = {sum[0], lo_q[WIDTH-1:1]};
        if (is_div) begin
            if (shifted >= {1'b0, opd_q}) begin
                nxt_up = rem_sub;
                nxt_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                nxt_up = shifted[WIDTH-1:0];
                nxt_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Work registers and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q  <= '0;
            lo_q  <= '0;
            opd_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            up_q  <= '0;
            lo_q  <= a_mag;
            opd_q <= b_mag;
            cnt_q <= CNT_W'(WIDTH);
        end else if (step) begin
            up_q  <= nxt_up;
            lo_q  <= nxt_lo;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign upper = up_q;
    assign lower = lo_q;
    assign last  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage HI/LO unit: iterative signed mult/div, mfhi/mflo, stall.
// Owns HI/LO; signs are stripped on accept and restored in FIX.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ALUCtl,
    input  logic             En,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Stall,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    hilo_state_t state_q, state_d;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic             sign_a_q, sign_b_q, op_div_q, dbz_q;
    logic             is_mult, is_div, is_hilo;
    logic             accept, dbz, start, step, last;
    logic [WIDTH-1:0] a_mag, b_mag, core_up, core_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quot_s, rem_s;

    assign is_mult = (ALUCtl == ALUCTL_MULT);
    assign is_div  = (ALUCtl == ALUCTL_DIV);
    assign is_hilo = is_mult | is_div |
                     (ALUCtl == ALUCTL_MFHI) | (ALUCtl == ALUCTL_MFLO);

    assign Busy   = (state_q != S_IDLE);
    assign accept = (state_q == S_IDLE) & En & (is_mult | is_div);
    assign dbz    = accept & is_div & (B == '0);
    assign start  = accept & ~dbz;
    assign Stall  = En & Busy & is_hilo;

    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    hilo_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .step   (step),
        .is_div (op_div_q),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .upper  (core_up),
        .lower  (core_lo),
        .last   (last)
    );

    // Sign restoration applied when the FIX state commits HI/LO.
    always_comb begin
        prod   = {core_up, core_lo};
        prod_s = (sign_a_q ^ sign_b_q) ? -prod : prod;
        quot_s = (sign_a_q ^ sign_b_q) ? -core_lo : core_lo;
        rem_s  = sign_a_q ? -core_up : core_up;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and iteration enable.
    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = is_div ? S_DIV : S_MUL;
            S_MUL, S_DIV: begin
                step = 1'b1;
                if (last) state_d = S_FIX;
            end
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand signs, HI/LO and divide-by-zero pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            op_div_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            dbz_q <= dbz;
            if (dbz) begin
                hi_q <= A;
                lo_q <= '1;
            end else if (start) begin
                sign_a_q <= A[WIDTH-1];
                sign_b_q <= B[WIDTH-1];
                op_div_q <= is_div;
            end else if (state_q == S_FIX) begin
                if (op_div_q) begin
                    hi_q <= rem_s;
                    lo_q <= quot_s;
                end else begin
                    hi_q <= prod_s[2*WIDTH-1:WIDTH];
                    lo_q <= prod_s[WIDTH-1:0];
                end
            end
        end
    end

    // mfhi/mflo read path, zero otherwise.
    always_comb begin
        Result = '0;
        if (En && !Busy) begin
            if (ALUCtl == ALUCTL_MFHI) Result = hi_q;
            else if (ALUCtl == ALUCTL_MFLO) Result = lo_q;
        end
    end

    assign DivByZero = dbz_q;
    assign HiOut     = hi_q;
    assign LoOut     = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit.
// Each scenario task checks its own hand-computed expectations.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ALUCtl = ALUCTL_ADD;
    logic        En = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Result;
    logic        Busy, Stall, DivByZero;
    logic [31:0] HiOut, LoOut;

    int vectors = 0;
    int miscompares = 0;

    hilo_muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUCtl    (ALUCtl),
        .En        (En),
        .A         (A),
        .B         (B),
        .Result    (Result),
        .Busy      (Busy),
        .Stall     (Stall),
        .DivByZero (DivByZero),
        .HiOut     (HiOut),
        .LoOut     (LoOut)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        En = 1'b1; ALUCtl = ctl; A = a; B = b;
        @(posedge clk);
        #1;
        En = 1'b0; ALUCtl = ALUCTL_ADD; A = 32'hDEADBEEF; B = 32'h12345678;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!Busy) break;
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: Busy still %b after %0d cycles, required 0", Busy, n);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", Busy); end
        vectors++;
        if (DivByZero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b want 0", DivByZero); end
        vectors++;
        if (HiOut !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", HiOut); end
        vectors++;
        if (LoOut !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", LoOut); end
        @(negedge clk);
        En = 1'b1; ALUCtl = ALUCTL_ADD;
        #1;
        vectors++;
        if (Result !== 32'h0) begin miscompares++; $display("FAIL reset_other_code: got %h want 0", Result); end
        En = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        issue(ALUCTL_MULT, 32'd7, 32'hFFFFFFFD);
        wait_idle(n);
        vectors++;
        if (n != 33) begin miscompares++; $display("FAIL mult_busy_len: got %0d want 33", n); end
        vectors++;
        if (HiOut !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi: got %h want ffffffff", HiOut); end
        vectors++;
        if (LoOut !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_lo: got %h want ffffffeb", LoOut); end
        En = 1'b1; ALUCtl = ALUCTL_MFHI;
        #1;
        vectors++;
        if (Result !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_mfhi: got %h want ffffffff", Result); end
        En = 1'b0;
    endtask

    task automatic test_div();
        int n;
        issue(ALUCTL_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        vectors++;
        if (n != 33) begin miscompares++; $display("FAIL div_busy_len: got %0d want 33", n); end
        vectors++;
        if (HiOut !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi: got %h want ffffffff", HiOut); end
        En = 1'b1; ALUCtl = ALUCTL_MFLO;
        #1;
        vectors++;
        if (Result !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_mflo: got %h want fffffffd", Result); end
        En = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        int k;
        issue(ALUCTL_MULT, 32'h00010000, 32'h00030000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        En = 1'b1; ALUCtl = ALUCTL_MFHI;
        #1;
        vectors++;
        if (Stall !== 1'b1) begin miscompares++; $display("FAIL b2b_stall_on: got %b want 1", Stall); end
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            #1;
            if (!Stall) break;
            k++;
        end
        vectors++;
        if (Busy !== 1'b0) begin miscompares++; $display("FAIL b2b_stall_release: busy %b want 0 (k=%0d)", Busy, k); end
        vectors++;
        if (Result !== 32'h3) begin miscompares++; $display("FAIL b2b_mfhi_new: got %h want 3", Result); end
        En = 1'b0;

        issue(ALUCTL_MULT, 32'h00020000, 32'h00030000);
        @(negedge clk);
        En = 1'b1; ALUCtl = ALUCTL_ADD;
        #1;
        vectors++;
        if (Stall !== 1'b0) begin miscompares++; $display("FAIL b2b_add_nostall: got %b want 0", Stall); end
        @(negedge clk);
        ALUCtl = ALUCTL_MULT; A = 32'd5; B = 32'd6;
        #1;
        vectors++;
        if (Stall !== 1'b1) begin miscompares++; $display("FAIL b2b_mult_stall: got %b want 1", Stall); end
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (!Busy) break;
            k++;
        end
        vectors++;
        if (HiOut !== 32'h6) begin miscompares++; $display("FAIL b2b_first_hi: got %h want 6", HiOut); end
        @(posedge clk);
        #1;
        En = 1'b0; ALUCtl = ALUCTL_ADD;
        vectors++;
        if (Busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_accept: got %b want 1", Busy); end
        wait_idle(n);
        vectors++;
        if (HiOut !== 32'h0 || LoOut !== 32'd30) begin
            miscompares++;
            $display("FAIL b2b_second_result: got %h_%h want 00000000_0000001e", HiOut, LoOut);
        end
    endtask

    task automatic test_divzero();
        issue(ALUCTL_DIV, 32'd5, 32'd0);
        @(negedge clk);
        vectors++;
        if (DivByZero !== 1'b1) begin miscompares++; $display("FAIL dbz_pulse: got %b want 1", DivByZero); end
        vectors++;
        if (Busy !== 1'b0) begin miscompares++; $display("FAIL dbz_busy: got %b want 0", Busy); end
        vectors++;
        if (HiOut !== 32'd5 || LoOut !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL dbz_hilo: got %h_%h want 00000005_ffffffff", HiOut, LoOut);
        end
        @(negedge clk);
        vectors++;
        if (DivByZero !== 1'b0) begin miscompares++; $display("FAIL dbz_one_cycle: got %b want 0", DivByZero); end
    endtask

    task automatic test_reset_mid();
        issue(ALUCTL_MULT, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (Busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", Busy); end
        vectors++;
        if (HiOut !== 32'h0 || LoOut !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_hilo: got %h_%h want 0_0", HiOut, LoOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        En = 1'b1; ALUCtl = ALUCTL_MFLO;
        #1;
        vectors++;
        if (Result !== 32'h0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_mflo: got %h busy %b want 0 busy 0", Result, Busy);
        end
        En = 1'b0;
    endtask

    task automatic test_corners();
        logic [3:0]  ctl [6];
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] ehi [6];
        logic [31:0] elo [6];
        int n;
        ctl[0] = ALUCTL_MULT; va[0] = 32'h80000000; vb[0] = 32'h80000000; ehi[0] = 32'h40000000; elo[0] = 32'h0;
        ctl[1] = ALUCTL_DIV;  va[1] = 32'h80000000; vb[1] = 32'hFFFFFFFF; ehi[1] = 32'h0;        elo[1] = 32'h80000000;
        ctl[2] = ALUCTL_DIV;  va[2] = 32'd0;        vb[2] = 32'd3;        ehi[2] = 32'h0;        elo[2] = 32'h0;
        ctl[3] = ALUCTL_MULT; va[3] = 32'hFFFFFFFE; vb[3] = 32'hFFFFFFFD; ehi[3] = 32'h0;        elo[3] = 32'd6;
        ctl[4] = ALUCTL_DIV;  va[4] = 32'd7;        vb[4] = 32'hFFFFFFFE; ehi[4] = 32'd1;        elo[4] = 32'hFFFFFFFD;
        ctl[5] = ALUCTL_DIV;  va[5] = 32'd100;      vb[5] = 32'd7;        ehi[5] = 32'd2;        elo[5] = 32'd14;
        for (int i = 0; i < 6; i++) begin
            issue(ctl[i], va[i], vb[i]);
            wait_idle(n);
            vectors++;
            if (HiOut !== ehi[i] || LoOut !== elo[i]) begin
                miscompares++;
                $display("FAIL corner_%0d: got %h_%h want %h_%h", i, HiOut, LoOut, ehi[i], elo[i]);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_mult();
        test_div();
        test_back_to_back();
        test_divzero();
        test_reset_mid();
        test_corners();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
